// File: rtl/wheel_mult_arbiter.sv
// wheel_mult_arbiter
//   Four requesters share one sign-magnitude fixed-point multiplier. A
//   round-robin arbiter picks one request per operation. The FSM steps
//   IDLE -> MUL -> DONE, so one operation can start every 3 cycles.
//
//   GNT is issued in the IDLE cycle that accepts a request. VALID follows
//   2 cycles later, in DONE, and goes to the requester that was granted.
//   RESULT and OVR are decoded from the registered product. They therefore
//   hold their value from one DONE until the next DONE.
//
// Configuration macro:
//   WHEEL_MULT_ARBITER_SATURATE_EN  defined   -> saturate magnitude to all ones on overflow
//                                   undefined -> truncate magnitude to its low N_WIDTH-1 bits
//
// Ports:
//   WHEEL_MULT_ARBITER_CLOCK         clock, rising edge
//   WHEEL_MULT_ARBITER_RESET_InHigh  asynchronous active-high reset
//   WHEEL_MULT_ARBITER_REQ_InBus     [3:0] request, bit i = requester i
//   WHEEL_MULT_ARBITER_A_InBus       [4*N-1:0] packed multiplicands
//   WHEEL_MULT_ARBITER_B_InBus       [4*N-1:0] packed multipliers
//   WHEEL_MULT_ARBITER_GNT_OutBus    [3:0] one-hot grant pulse
//   WHEEL_MULT_ARBITER_RESULT_OutBus [N-1:0] sign-magnitude Q product
//   WHEEL_MULT_ARBITER_VALID_OutBus  [3:0] one-hot result-valid pulse
//   WHEEL_MULT_ARBITER_OVR_Out       overflow flag (qualified by VALID)
//   WHEEL_MULT_ARBITER_BUSY_Out      high whenever not IDLE
module wheel_mult_arbiter #(
  parameter int N_WIDTH = 17,
  parameter int Q_WIDTH = 8
) (
  input  logic                   WHEEL_MULT_ARBITER_CLOCK,
  input  logic                   WHEEL_MULT_ARBITER_RESET_InHigh,
  input  logic [3:0]             WHEEL_MULT_ARBITER_REQ_InBus,
  input  logic [4*N_WIDTH-1:0]   WHEEL_MULT_ARBITER_A_InBus,
  input  logic [4*N_WIDTH-1:0]   WHEEL_MULT_ARBITER_B_InBus,
  output logic [3:0]             WHEEL_MULT_ARBITER_GNT_OutBus,
  output logic [N_WIDTH-1:0]     WHEEL_MULT_ARBITER_RESULT_OutBus,
  output logic [3:0]             WHEEL_MULT_ARBITER_VALID_OutBus,
  output logic                   WHEEL_MULT_ARBITER_OVR_Out,
  output logic                   WHEEL_MULT_ARBITER_BUSY_Out
);

  localparam int MW = N_WIDTH - 1;   // magnitude width
  localparam int PW = 2 * MW;        // full product width

  typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;

  logic clk, rst;
  assign clk = WHEEL_MULT_ARBITER_CLOCK;
  assign rst = WHEEL_MULT_ARBITER_RESET_InHigh;

  state_t               state, state_nxt;
  logic [1:0]           last_grant;
  logic [N_WIDTH-1:0]   a_lat, b_lat;
  logic [PW-1:0]        prod_mag;
  logic                 prod_sign;

  // Round-robin pick. The search starts just after the last winner.
  logic [1:0] pick;
  logic       any_req;
  always_comb begin
    pick    = '0;
    any_req = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      logic [1:0] idx;
      idx = last_grant + 2'(k);
      if (!any_req && WHEEL_MULT_ARBITER_REQ_InBus[idx]) begin
        any_req = 1'b1;
        pick    = idx;
      end
    end
  end

  // Next state and Mealy grant. The grant is gated by reset, so no pulse
  // can leak out while reset is held.
  logic take;
  always_comb begin
    state_nxt = state;
    take      = 1'b0;
    WHEEL_MULT_ARBITER_GNT_OutBus = '0;
    case (state)
      IDLE: if (any_req && !rst) begin
        take      = 1'b1;
        state_nxt = MUL;
        WHEEL_MULT_ARBITER_GNT_OutBus = 4'b0001 << pick;
      end
      MUL:     state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Operands are latched at grant. Later changes on the buses are ignored.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant <= 2'd3;
      a_lat      <= '0;
      b_lat      <= '0;
    end else if (take) begin
      last_grant <= pick;
      a_lat      <= WHEEL_MULT_ARBITER_A_InBus[pick*N_WIDTH +: N_WIDTH];
      b_lat      <= WHEEL_MULT_ARBITER_B_InBus[pick*N_WIDTH +: N_WIDTH];
    end
  end

  // Full-width magnitude product. It is registered at the end of MUL, so it
  // is valid throughout DONE and stays put until the next operation.
  logic [PW-1:0] mul_full;
  assign mul_full = {{MW{1'b0}}, a_lat[MW-1:0]} * {{MW{1'b0}}, b_lat[MW-1:0]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prod_mag  <= '0;
      prod_sign <= 1'b0;
    end else if (state == MUL) begin
      prod_mag  <= mul_full;
      prod_sign <= a_lat[N_WIDTH-1] ^ b_lat[N_WIDTH-1];
    end
  end

  // Result decode from the registered product.
  logic [PW-1:0] shifted;
  logic          ovr;
  logic [MW-1:0] mag_out;
  assign shifted = prod_mag >> Q_WIDTH;
  assign ovr     = |shifted[PW-1:MW];

`ifdef WHEEL_MULT_ARBITER_SATURATE_EN
  assign mag_out = ovr ? {MW{1'b1}} : shifted[MW-1:0];
`else
  assign mag_out = shifted[MW-1:0];
`endif

  // A zero magnitude is always reported as +0.
  assign WHEEL_MULT_ARBITER_RESULT_OutBus = {prod_sign & (|mag_out), mag_out};
  assign WHEEL_MULT_ARBITER_OVR_Out       = ovr;
  assign WHEEL_MULT_ARBITER_VALID_OutBus  = (state == DONE) ? (4'b0001 << last_grant) : 4'b0000;
  assign WHEEL_MULT_ARBITER_BUSY_Out      = (state != IDLE);

endmodule

// File: tb/tb_wheel_mult_arbiter.sv
module tb_wheel_mult_arbiter;
  localparam int N = 17;
  localparam int Q = 8;

  logic           clk = 1'b0;
  logic           rst;
  logic [3:0]     req;
  logic [4*N-1:0] a_bus, b_bus;
  logic [3:0]     gnt, valid;
  logic [N-1:0]   result;
  logic           ovr, busy;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  wheel_mult_arbiter #(.N_WIDTH(N), .Q_WIDTH(Q)) dut (
    .WHEEL_MULT_ARBITER_CLOCK         (clk),
    .WHEEL_MULT_ARBITER_RESET_InHigh  (rst),
    .WHEEL_MULT_ARBITER_REQ_InBus     (req),
    .WHEEL_MULT_ARBITER_A_InBus       (a_bus),
    .WHEEL_MULT_ARBITER_B_InBus       (b_bus),
    .WHEEL_MULT_ARBITER_GNT_OutBus    (gnt),
    .WHEEL_MULT_ARBITER_RESULT_OutBus (result),
    .WHEEL_MULT_ARBITER_VALID_OutBus  (valid),
    .WHEEL_MULT_ARBITER_OVR_Out       (ovr),
    .WHEEL_MULT_ARBITER_BUSY_Out      (busy)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Runs one operation from requester idx and checks it cycle by cycle.
  // The operand buses are scrambled after the grant to confirm that the
  // operands were latched.
  task automatic run_op(input int idx, input logic [N-1:0] a, input logic [N-1:0] b,
                        input logic [N-1:0] exp_res, input logic exp_ovr, input string tag);
    logic [3:0] oh;
    oh = 4'b0001 << idx;
    @(negedge clk);
    req = oh;
    a_bus[idx*N +: N] = a;
    b_bus[idx*N +: N] = b;
    #1 chk({tag, ".gnt"}, 32'(gnt), 32'(oh));
    chk({tag, ".valid_t"}, 32'(valid), 32'h0);
    @(negedge clk);                     // MUL
    req = 4'b0000;
    a_bus = '1;
    b_bus = '1;
    #1 chk({tag, ".gnt_mul"}, 32'(gnt), 32'h0);
    chk({tag, ".busy_mul"}, 32'(busy), 32'h1);
    chk({tag, ".valid_mul"}, 32'(valid), 32'h0);
    @(negedge clk);                     // DONE
    #1 chk({tag, ".valid"}, 32'(valid), 32'(oh));
    chk({tag, ".result"}, 32'(result), 32'(exp_res));
    chk({tag, ".ovr"}, 32'(ovr), 32'(exp_ovr));
    @(negedge clk);                     // back to IDLE, result held
    #1 chk({tag, ".valid_after"}, 32'(valid), 32'h0);
    chk({tag, ".result_hold"}, 32'(result), 32'(exp_res));
    chk({tag, ".busy_idle"}, 32'(busy), 32'h0);
  endtask

  initial begin
    logic [N-1:0] sat_exp;
`ifdef WHEEL_MULT_ARBITER_SATURATE_EN
    sat_exp = 17'h0FFFF;
`else
    sat_exp = 17'h0FE00;
`endif
    rst = 1'b1; req = 4'b0000; a_bus = '0; b_bus = '0;
    #1;
    chk("rst.gnt",    32'(gnt),    32'h0);
    chk("rst.valid",  32'(valid),  32'h0);
    chk("rst.result", 32'(result), 32'h0);
    chk("rst.ovr",    32'(ovr),    32'h0);
    chk("rst.busy",   32'(busy),   32'h0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;

    run_op(0, 17'h00A00, 17'h004C5, 17'h02FB2, 1'b0, "pos");
    run_op(1, 17'h10200, 17'h00300, 17'h10600, 1'b0, "neg");
    run_op(2, 17'h0FF00, 17'h00200, sat_exp,   1'b1, "ovf");
    run_op(3, 17'h10000, 17'h00100, 17'h00000, 1'b0, "zero");

    // Round robin with all four requesters held from reset.
    @(negedge clk);
    rst = 1'b1; req = 4'b1111;
    #1 chk("rr.gnt_in_rst", 32'(gnt), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      logic [3:0] e;
      e = 4'b0001 << (k % 4);
      #1 chk($sformatf("rr%0d.gnt", k), 32'(gnt), 32'(e));
      @(negedge clk);
      #1 chk($sformatf("rr%0d.gnt_mul", k), 32'(gnt), 32'h0);
      @(negedge clk);
      #1 chk($sformatf("rr%0d.valid", k), 32'(valid), 32'(e));
      @(negedge clk);
    end

    // Reset during MUL abandons the operation.
    rst = 1'b1; req = 4'b0000;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    req = 4'b0001;
    a_bus[0 +: N] = 17'h00A00; b_bus[0 +: N] = 17'h004C5;
    @(negedge clk);                     // MUL
    req = 4'b0000;
    rst = 1'b1;
    #1 chk("mrst.gnt",    32'(gnt),    32'h0);
    chk("mrst.valid",  32'(valid),  32'h0);
    chk("mrst.result", 32'(result), 32'h0);
    chk("mrst.ovr",    32'(ovr),    32'h0);
    chk("mrst.busy",   32'(busy),   32'h0);
    @(negedge clk);
    #1 chk("mrst.valid_held", 32'(valid), 32'h0);
    req = 4'b0100;
    @(negedge clk);
    rst = 1'b0;
    #1 chk("mrst.gnt_after", 32'(gnt), 32'h4);
    @(negedge clk);
    req = 4'b0000;
    @(negedge clk);
    #1 chk("mrst.valid_after", 32'(valid), 32'h4);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
